// File: rtl/data_mem_responder.sv
// Data memory responder: one request at a time, ready strobe LATENCY edges after acceptance.
// Requests arriving while busy or responding are dropped rather than queued.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        ready,
    output logic [31:0] rdata,
    output logic        err
);
    localparam int AW = $clog2(DEPTH_WORDS);

    // Encoding puts busy on bit 0 and ready on bit 1 so outputs decode glitch-free.
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_WAIT = 2'b01,
        S_RESP = 2'b10
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [3:0]    r_cnt;
    logic          r_op_rd;
    logic          r_op_wr;
    logic [2:0]    r_funct3;
    logic [AW+1:0] r_addr;
    logic [31:0]   r_wdata;
    logic [31:0]   r_rdata;
    logic          r_err;
    logic [31:0]   r_mem [DEPTH_WORDS];

    logic          w_accept;
    logic          w_resp_edge;
    logic          w_illegal;
    logic          w_misalign;
    logic          w_err;
    logic [AW-1:0] w_idx;
    logic [31:0]   w_word;
    logic [7:0]    w_byte;
    logic [15:0]   w_half;
    logic [31:0]   w_load;
    logic [3:0]    w_be;
    logic [31:0]   w_wlane;
    logic          w_commit;
    logic          w_unused;

    assign w_accept    = (r_state == S_IDLE) && (mem_read || mem_write);
    assign w_resp_edge = (r_state == S_WAIT) && (r_cnt == 4'd0);
    assign w_unused    = ^addr[31:AW+2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (mem_read || mem_write) w_next = S_WAIT;
            S_WAIT:  if (r_cnt == 4'd0) w_next = S_RESP;
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy  = r_state[0];
        ready = r_state[1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= 4'd0;
            r_op_rd  <= 1'b0;
            r_op_wr  <= 1'b0;
            r_funct3 <= 3'd0;
            r_addr   <= '0;
            r_wdata  <= 32'd0;
        end else if (w_accept) begin
            r_cnt    <= 4'(LATENCY - 1);
            r_op_rd  <= mem_read;
            r_op_wr  <= mem_write;
            r_funct3 <= funct3;
            r_addr   <= addr[AW+1:0];
            r_wdata  <= wdata;
        end else if (r_state == S_WAIT && r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    // Legal loads: B/H/W/BU/HU; legal stores: B/H/W only.
    assign w_illegal  = (r_op_rd && r_op_wr) ||
                        (r_op_wr && (r_funct3[2] || r_funct3[1:0] == 2'b11)) ||
                        (r_op_rd && (r_funct3[1:0] == 2'b11 || r_funct3 == 3'b110));
    assign w_misalign = (r_funct3[1:0] == 2'b01 && r_addr[0]) ||
                        (r_funct3[1:0] == 2'b10 && r_addr[1:0] != 2'b00);
    assign w_err      = w_illegal || w_misalign;

    assign w_idx  = r_addr[AW+1:2];
    assign w_word = r_mem[w_idx];
    assign w_byte = w_word[{r_addr[1:0], 3'b000} +: 8];
    assign w_half = r_addr[1] ? w_word[31:16] : w_word[15:0];

    always_comb begin
        w_load = 32'd0;
        case (r_funct3)
            3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load = {{16{w_half[15]}}, w_half};
            3'b010:  w_load = w_word;
            3'b100:  w_load = {24'd0, w_byte};
            3'b101:  w_load = {16'd0, w_half};
            default: w_load = 32'd0;
        endcase
    end

    always_comb begin
        w_be    = 4'b1111;
        w_wlane = r_wdata;
        case (r_funct3[1:0])
            2'b00: begin
                w_be    = 4'b0001 << r_addr[1:0];
                w_wlane = {4{r_wdata[7:0]}};
            end
            2'b01: begin
                w_be    = r_addr[1] ? 4'b1100 : 4'b0011;
                w_wlane = {2{r_wdata[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wlane = r_wdata;
            end
        endcase
    end

    assign w_commit = w_resp_edge && r_op_wr && !w_err;

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (w_commit) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) r_mem[w_idx][i*8 +: 8] <= w_wlane[i*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else if (w_resp_edge) begin
            r_rdata <= (r_op_rd && !w_err) ? w_load : 32'd0;
            r_err   <= w_err;
        end else if (r_state == S_RESP) begin
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end
    end

    assign rdata = r_rdata;
    assign err   = r_err;
endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed scenarios plus randomized traffic against a byte-array model.
module tb_data_mem_responder;
    localparam int LAT   = 2;
    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic        busy;
    logic        ready;
    logic [31:0] rdata;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] mdl [DEPTH*4];

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .funct3(funct3), .addr(addr), .wdata(wdata),
        .busy(busy), .ready(ready), .rdata(rdata), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic model_err(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] a);
        if (rd && wr) return 1'b1;
        if (wr && !(f3 inside {3'd0, 3'd1, 3'd2})) return 1'b1;
        if (rd && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b1;
        if ((f3 == 3'd1 || f3 == 3'd5) && a[0]) return 1'b1;
        if (f3 == 3'd2 && a[1:0] != 2'b00) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
        logic [9:0]  b;
        logic [31:0] w;
        b = a[9:0];
        w = {mdl[10'(b + 10'd3)], mdl[10'(b + 10'd2)], mdl[10'(b + 10'd1)], mdl[b]};
        case (f3)
            3'd0: return 32'($signed(w[7:0]));
            3'd1: return 32'($signed(w[15:0]));
            3'd2: return w;
            3'd4: return {24'd0, w[7:0]};
            3'd5: return {16'd0, w[15:0]};
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] model_expect(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] a);
        if (model_err(rd, wr, f3, a) || wr) return 32'd0;
        return model_load(f3, a);
    endfunction

    task automatic model_apply(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        int n;
        logic [9:0] b;
        if (!wr || model_err(rd, wr, f3, a)) return;
        n = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
        for (int i = 0; i < n; i++) begin
            b = 10'(a[9:0] + 10'(i));
            mdl[b] = wd[i*8 +: 8];
        end
    endtask

    task automatic txn(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_er, input string name);
        int lat;
        lat = -1;
        @(negedge clk);
        mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd;
        @(posedge clk);
        @(negedge clk);
        mem_read = 1'b0; mem_write = 1'b0;
        funct3 = 3'($urandom); addr = $urandom; wdata = $urandom;
        for (int k = 0; k < 20 && lat < 0; k++) begin
            if (ready === 1'b1) lat = k;
            else begin
                @(posedge clk);
                @(negedge clk);
            end
        end
        n_checks++;
        if (lat !== LAT) begin
            n_fail++;
            $display("FAIL %s latency got %0d want %0d", name, lat, LAT);
        end
        if (lat >= 0) begin
            n_checks++;
            if (rdata !== exp_rd) begin
                n_fail++;
                $display("FAIL %s rdata got %h want %h", name, rdata, exp_rd);
            end
            n_checks++;
            if (err !== exp_er) begin
                n_fail++;
                $display("FAIL %s err got %b want %b", name, err, exp_er);
            end
            @(posedge clk);
            @(negedge clk);
            n_checks++;
            if (ready !== 1'b0) begin
                n_fail++;
                $display("FAIL %s ready_one_cycle got %b want 0", name, ready);
            end
        end
        model_apply(rd, wr, f3, a, wd);
    endtask

    task automatic mtxn(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input string name);
        txn(rd, wr, f3, a, wd, model_expect(rd, wr, f3, a), model_err(rd, wr, f3, a), name);
    endtask

    task automatic test_reset();
        #2;
        n_checks++;
        if ({busy, ready, err, rdata} !== 35'd0) begin
            n_fail++;
            $display("FAIL reset_outputs got busy=%b ready=%b err=%b rdata=%h want all 0", busy, ready, err, rdata);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_init();
        for (int w = 0; w < DEPTH; w++) mtxn(1'b0, 1'b1, 3'd2, 32'(w * 4), $urandom, "init_sw");
    endtask

    task automatic test_directed();
        txn(1'b0, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 32'd0, 1'b0, "sw_10");
        txn(1'b1, 1'b0, 3'd2, 32'h10, 32'd0, 32'hDEADBEEF, 1'b0, "lw_10");
        txn(1'b1, 1'b0, 3'd0, 32'h13, 32'd0, 32'hFFFFFFDE, 1'b0, "lb_13");
        txn(1'b1, 1'b0, 3'd4, 32'h13, 32'd0, 32'h000000DE, 1'b0, "lbu_13");
        txn(1'b1, 1'b0, 3'd5, 32'h12, 32'd0, 32'h0000DEAD, 1'b0, "lhu_12");
        txn(1'b1, 1'b0, 3'd1, 32'h10, 32'd0, 32'hFFFFBEEF, 1'b0, "lh_10");
        txn(1'b0, 1'b1, 3'd0, 32'h11, 32'h55, 32'd0, 1'b0, "sb_11");
        txn(1'b1, 1'b0, 3'd2, 32'h10, 32'd0, 32'hDEAD55EF, 1'b0, "lw_after_sb");
        txn(1'b0, 1'b1, 3'd2, 32'h410, 32'h1, 32'd0, 1'b0, "sw_wrap");
        txn(1'b1, 1'b0, 3'd2, 32'h10, 32'd0, 32'h00000001, 1'b0, "lw_after_wrap");
    endtask

    task automatic test_errors();
        txn(1'b1, 1'b0, 3'd2, 32'h12, 32'd0, 32'd0, 1'b1, "lw_misaligned");
        txn(1'b0, 1'b1, 3'd1, 32'h13, 32'hFFFF, 32'd0, 1'b1, "sh_misaligned");
        txn(1'b1, 1'b1, 3'd2, 32'h10, 32'hAAAAAAAA, 32'd0, 1'b1, "rd_and_wr");
        txn(1'b0, 1'b1, 3'd4, 32'h10, 32'hBBBBBBBB, 32'd0, 1'b1, "sbu_illegal");
        txn(1'b1, 1'b0, 3'd3, 32'h10, 32'd0, 32'd0, 1'b1, "ld_f3_011");
        txn(1'b1, 1'b0, 3'd2, 32'h10, 32'd0, 32'h00000001, 1'b0, "lw_unchanged");
    endtask

    task automatic test_reset_abort();
        int n_rdy;
        n_rdy = 0;
        @(negedge clk);
        mem_write = 1'b1; funct3 = 3'd2; addr = 32'h20; wdata = 32'h12345678;
        @(posedge clk);
        @(negedge clk);
        mem_write = 1'b0;
        rst = 1'b1;
        #1;
        n_checks++;
        if (busy !== 1'b0 || ready !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_async got busy=%b ready=%b want 0 0", busy, ready);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (ready === 1'b1) n_rdy++;
            @(negedge clk);
        end
        n_checks++;
        if (n_rdy != 0) begin
            n_fail++;
            $display("FAIL abort_no_ready got %0d readies want 0", n_rdy);
        end
        mtxn(1'b1, 1'b0, 3'd2, 32'h20, 32'd0, "lw_after_abort");
    endtask

    task automatic test_back_to_back();
        int rdy_k [$];
        logic [31:0] exp_ld;
        exp_ld = model_load(3'd2, 32'h40);
        @(negedge clk);
        mem_read = 1'b1; funct3 = 3'd2; addr = 32'h40;
        @(posedge clk);
        @(negedge clk);
        mem_read = 1'b0; mem_write = 1'b1; funct3 = 3'd2; addr = 32'h44; wdata = 32'hCAFEF00D;
        for (int k = 0; k <= 10; k++) begin
            if (ready === 1'b1) rdy_k.push_back(k);
            if (k == 2) begin
                n_checks++;
                if (rdata !== exp_ld) begin
                    n_fail++;
                    $display("FAIL b2b_first_rdata got %h want %h", rdata, exp_ld);
                end
            end
            if (k == 3 || k == 4) begin
                n_checks++;
                if (busy !== (k == 4)) begin
                    n_fail++;
                    $display("FAIL b2b_busy_k%0d got %b want %b", k, busy, (k == 4));
                end
            end
            if (k == 4) mem_write = 1'b0;
            @(negedge clk);
        end
        model_apply(1'b0, 1'b1, 3'd2, 32'h44, 32'hCAFEF00D);
        n_checks++;
        if (rdy_k.size() != 2 || rdy_k[0] != 2 || rdy_k[1] != 6) begin
            n_fail++;
            $display("FAIL b2b_ready_cycles got %p want '{2,6}", rdy_k);
        end
        mtxn(1'b1, 1'b0, 3'd2, 32'h44, 32'd0, "b2b_lw_44");
    endtask

    task automatic test_random();
        logic rd, wr;
        logic [2:0] f3;
        logic [31:0] a;
        int r;
        for (int t = 0; t < 300; t++) begin
            r = $urandom_range(0, 9);
            rd = (r == 0) || (r >= 5);
            wr = (r <= 4);
            f3 = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0) f3 = wr ? 3'($urandom_range(0, 2)) : 3'(($urandom_range(0, 4) == 3) ? 4 : $urandom_range(0, 2));
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a = (f3[1:0] == 2'd2) ? {a[31:2], 2'b00} : (f3[1:0] == 2'd1) ? {a[31:1], 1'b0} : a;
            mtxn(rd, wr, f3, a, $urandom, "random");
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_directed();
        test_errors();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
